adc_round_robin_sched: RTL and testbench
========================================

Name: adc_round_robin_sched

Overview:
- Sequences the shared 12-bit ADC front end and shares it between the two player input channels (ch0 = player 1, ch1 = player 2).
- On each sample tick it runs one conversion round: ch0 only in single mode, ch0 then ch1 in multi mode.
- It publishes both results together with a one-cycle strobe, so the single-player threshold decoder and the tug-of-war FSM step on coherent data.

Parameters:
- SAMPLE_DIV, 50000: clk cycles between round starts; minimum 4.
- DW, 12: ADC result width.
- TIMEOUT, 1023: maximum cycles to wait for conv_done before the round is abandoned.

Ports:
- clk  in  1  system clock
- reset_n  in  1  synchronous reset, active-low
- enable  in  1  1 = scheduler runs; 0 = return to IDLE
- mode  in  1  0 = single (ch0 only), 1 = multi (ch0 then ch1)
- conv_start  out  1  one-cycle pulse requesting a conversion
- conv_ch  out  1  channel select; stable from conv_start until conv_done
- conv_done  in  1  one-cycle pulse from the ADC interface; conv_data valid in that cycle
- conv_data  in  DW  conversion result
- p1data  out  DW  published ch0 result
- p2data  out  DW  published ch1 result
- sample_valid  out  1  one-cycle strobe; p1data/p2data updated in the same cycle
- timeout_err  out  1  sticky; set when a conversion times out
- overrun  out  1  sticky; set when a tick arrives while a round is in progress

Behaviour:
- Reset (reset_n = 0 at a clk edge): state IDLE, tick counter 0, all outputs 0, shadow registers 0.
- Tick counter:
  - Counts only while enable = 1.
  - Wraps at SAMPLE_DIV-1 and produces an internal tick that cycle.
  - Cleared whenever enable = 0.
- States:
  - IDLE: exits to WAIT_TICK when enable = 1.
  - WAIT_TICK: goes to START on tick. Latches mode into round_mode and sets conv_ch = 0.
  - START: conv_start = 1 for exactly this cycle. Goes to WAIT_DONE with the timeout counter cleared.
  - WAIT_DONE: on conv_done, captures conv_data into the shadow register for conv_ch.
    - If conv_ch = 0 and round_mode = 1: set conv_ch = 1, go to START.
    - Otherwise: go to PUBLISH.
  - PUBLISH: loads p1data from shadow0. Loads p2data from shadow1 only if round_mode = 1, otherwise p2data holds. Asserts sample_valid, then goes to WAIT_TICK.
- Latency:
  - conv_start fires the cycle after the tick.
  - sample_valid is asserted exactly 1 cycle after the last accepted conv_done.
- conv_done outside WAIT_DONE, including the START cycle, is ignored.
- Timeout: if the WAIT_DONE counter reaches TIMEOUT without conv_done:
  - set timeout_err;
  - abandon the round: no sample_valid, p1data/p2data unchanged, shadow registers discarded;
  - go to WAIT_TICK.
- Overrun: a tick occurring in any state other than WAIT_TICK sets overrun. The tick is dropped; the round is not restarted.
- A mode change mid-round has no effect until the next round.
- enable = 0 in any state: next state IDLE, no publish, conv_start = 0. Sticky flags and published data are held.
- Sticky flags clear only on reset.
- Simultaneous conv_done and timeout terminal count in the same cycle: conv_done wins.

Optional Feature:
- Macro: ADC_AVG_EN.
- Defined:
  - Each channel is converted twice back-to-back (two START/WAIT_DONE passes per channel).
  - Published value = (a + b) >> 1, using a DW+1-bit sum truncated after the shift.
  - Timeout on either pass abandons the whole round.
  - Latency from the last done to sample_valid is still 1 cycle.
- Undefined: one conversion per channel as above.

Test Plan:
- Bench uses SAMPLE_DIV = 8, TIMEOUT = 16, ADC model answering 3 cycles after conv_start.
1. Reset then enable = 1, mode = 0, ch0 returns 0x3E8 -> conv_start pulses with conv_ch = 0 every 8 cycles; sample_valid 1 cycle after done; p1data = 0x3E8; p2data stays 0x000.
2. mode = 1, ch0 = 0x123, ch1 = 0xABC -> two conv_start pulses (conv_ch 0 then 1); a single sample_valid with p1data = 0x123, p2data = 0xABC.
3. ADC model never answers ch1 -> timeout_err = 1 after 16 cycles in WAIT_DONE; no sample_valid; outputs keep their previous values; the next round proceeds normally.
4. ADC latency raised to 10 cycles in multi mode -> overrun = 1; each round completes and publishes correctly.
5. enable dropped while waiting for ch1 done -> no sample_valid; state IDLE next cycle; re-enable restarts with conv_ch = 0 after 8 cycles.
6. ADC_AVG_EN defined, ch0 returns 0x100 then 0x103 -> p1data = 0x101; four conv_start pulses per multi-mode round.

Source files
------------

// File: rtl/adc_round_robin_sched_if.sv
// Conversion handshake between the round-robin scheduler (master) and the
// shared ADC front end (slave).
interface adc_round_robin_sched_if #(
  parameter int unsigned DW = 12
);
  logic          conv_start;
  logic          conv_ch;
  logic          conv_done;
  logic [DW-1:0] conv_data;

  modport master (
    output conv_start,
    output conv_ch,
    input  conv_done,
    input  conv_data
  );

  modport slave (
    input  conv_start,
    input  conv_ch,
    output conv_done,
    output conv_data
  );
endinterface

// File: rtl/adc_round_robin_sched.sv
// Shares one ADC between player channels: one conversion round per sample tick,
// results published together. Define ADC_AVG_EN to average two conversions per channel.
module adc_round_robin_sched #(
  parameter int unsigned SAMPLE_DIV = 50000,
  parameter int unsigned DW         = 12,
  parameter int unsigned TIMEOUT    = 1023
) (
  input  logic                           clk,
  input  logic                           reset_n,
  input  logic                           enable,
  input  logic                           mode,
  adc_round_robin_sched_if.master        adc,
  output logic [DW-1:0]                  p1data,
  output logic [DW-1:0]                  p2data,
  output logic                           sample_valid,
  output logic                           timeout_err,
  output logic                           overrun
);

  localparam int unsigned CW = (SAMPLE_DIV > 1) ? $clog2(SAMPLE_DIV) : 1;
  localparam int unsigned TW = $clog2(TIMEOUT + 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_WAIT_TICK,
    S_START,
    S_WAIT_DONE,
    S_PUBLISH
  } state_t;

  state_t        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [TW-1:0] to_cnt_q, to_cnt_d;
  logic          round_mode_q, round_mode_d;
  logic          conv_ch_q, conv_ch_d;
  logic          conv_start_q, conv_start_d;
  logic [DW-1:0] shadow0_q, shadow0_d;
  logic [DW-1:0] shadow1_q, shadow1_d;
  logic [DW-1:0] p1data_q, p1data_d;
  logic [DW-1:0] p2data_q, p2data_d;
  logic          sample_valid_q, sample_valid_d;
  logic          timeout_err_q, timeout_err_d;
  logic          overrun_q, overrun_d;
  logic          tick;
  logic [DW-1:0] sample;

`ifdef ADC_AVG_EN
  logic          pass_q, pass_d;
  logic [DW-1:0] acc_q, acc_d;
  logic [DW:0]   sum;

  always_comb begin
    sum    = {1'b0, acc_q} + {1'b0, adc.conv_data};
    sample = sum[DW:1];
  end
`else
  always_comb begin
    sample = adc.conv_data;
  end
`endif

  always_comb begin
    tick           = enable && (cnt_q == CW'(SAMPLE_DIV - 1));
    cnt_d          = '0;
    if (enable && !tick) cnt_d = cnt_q + CW'(1);

    state_d        = state_q;
    to_cnt_d       = to_cnt_q;
    round_mode_d   = round_mode_q;
    conv_ch_d      = conv_ch_q;
    conv_start_d   = 1'b0;
    shadow0_d      = shadow0_q;
    shadow1_d      = shadow1_q;
    p1data_d       = p1data_q;
    p2data_d       = p2data_q;
    sample_valid_d = 1'b0;
    timeout_err_d  = timeout_err_q;
    overrun_d      = overrun_q;
`ifdef ADC_AVG_EN
    pass_d         = pass_q;
    acc_d          = acc_q;
`endif

    if (!enable) begin
      state_d = S_IDLE;
    end else begin
      if (tick && (state_q != S_WAIT_TICK)) overrun_d = 1'b1;

      case (state_q)
        S_IDLE: state_d = S_WAIT_TICK;

        S_WAIT_TICK: begin
          conv_ch_d = 1'b0;
          if (tick) begin
            round_mode_d = mode;
            conv_start_d = 1'b1;
            state_d      = S_START;
`ifdef ADC_AVG_EN
            pass_d       = 1'b0;
`endif
          end
        end

        S_START: begin
          to_cnt_d = '0;
          state_d  = S_WAIT_DONE;
        end

        S_WAIT_DONE: begin
          if (adc.conv_done) begin
            to_cnt_d = '0;
`ifdef ADC_AVG_EN
            if (!pass_q) begin
              acc_d        = adc.conv_data;
              pass_d       = 1'b1;
              conv_start_d = 1'b1;
              state_d      = S_START;
            end else
`endif
            begin
`ifdef ADC_AVG_EN
              pass_d = 1'b0;
`endif
              if (conv_ch_q) shadow1_d = sample;
              else           shadow0_d = sample;
              if (!conv_ch_q && round_mode_q) begin
                conv_ch_d    = 1'b1;
                conv_start_d = 1'b1;
                state_d      = S_START;
              end else begin
                // Outputs are registered, so the publish load happens on entry to
                // PUBLISH, bypassing the shadow for the channel finishing now.
                p1data_d       = conv_ch_q ? shadow0_q : sample;
                if (round_mode_q) p2data_d = sample;
                sample_valid_d = 1'b1;
                state_d        = S_PUBLISH;
              end
            end
          end else if (to_cnt_q == TW'(TIMEOUT - 1)) begin
            timeout_err_d = 1'b1;
            state_d       = S_WAIT_TICK;
          end else begin
            to_cnt_d = to_cnt_q + TW'(1);
          end
        end

        S_PUBLISH: state_d = S_WAIT_TICK;

        default: state_d = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q        <= S_IDLE;
      cnt_q          <= '0;
      to_cnt_q       <= '0;
      round_mode_q   <= 1'b0;
      conv_ch_q      <= 1'b0;
      conv_start_q   <= 1'b0;
      shadow0_q      <= '0;
      shadow1_q      <= '0;
      p1data_q       <= '0;
      p2data_q       <= '0;
      sample_valid_q <= 1'b0;
      timeout_err_q  <= 1'b0;
      overrun_q      <= 1'b0;
`ifdef ADC_AVG_EN
      pass_q         <= 1'b0;
      acc_q          <= '0;
`endif
    end else begin
      state_q        <= state_d;
      cnt_q          <= cnt_d;
      to_cnt_q       <= to_cnt_d;
      round_mode_q   <= round_mode_d;
      conv_ch_q      <= conv_ch_d;
      conv_start_q   <= conv_start_d;
      shadow0_q      <= shadow0_d;
      shadow1_q      <= shadow1_d;
      p1data_q       <= p1data_d;
      p2data_q       <= p2data_d;
      sample_valid_q <= sample_valid_d;
      timeout_err_q  <= timeout_err_d;
      overrun_q      <= overrun_d;
`ifdef ADC_AVG_EN
      pass_q         <= pass_d;
      acc_q          <= acc_d;
`endif
    end
  end

  assign adc.conv_start = conv_start_q;
  assign adc.conv_ch    = conv_ch_q;
  assign p1data         = p1data_q;
  assign p2data         = p2data_q;
  assign sample_valid   = sample_valid_q;
  assign timeout_err    = timeout_err_q;
  assign overrun        = overrun_q;

endmodule

// File: tb/tb_adc_round_robin_sched.sv
// Bench for adc_round_robin_sched: ADC responder, round-level reference model
// compared every cycle, plus hand-computed scenario checkpoints.
module tb_adc_round_robin_sched;

  localparam int unsigned DW         = 12;
  localparam int unsigned SAMPLE_DIV = 8;
  localparam int unsigned TIMEOUT    = 16;
`ifdef ADC_AVG_EN
  localparam int NPASS = 2;
`else
  localparam int NPASS = 1;
`endif

  logic          clk = 1'b0;
  logic          reset_n;
  logic          enable;
  logic          mode;
  logic [DW-1:0] p1data, p2data;
  logic          sample_valid, timeout_err, overrun;

  adc_round_robin_sched_if #(.DW(DW)) bus ();

  adc_round_robin_sched #(
    .SAMPLE_DIV(SAMPLE_DIV),
    .DW        (DW),
    .TIMEOUT   (TIMEOUT)
  ) dut (
    .clk         (clk),
    .reset_n     (reset_n),
    .enable      (enable),
    .mode        (mode),
    .adc         (bus),
    .p1data      (p1data),
    .p2data      (p2data),
    .sample_valid(sample_valid),
    .timeout_err (timeout_err),
    .overrun     (overrun)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // ADC responder: answers adc_lat cycles after the conv_start cycle
  int            adc_lat;
  bit            mute[2];
  logic [DW-1:0] adc_val[2][2];
  int            cd;
  logic          pend_ch;
  int            seq[2];

  initial begin
    cd = 0;
    pend_ch = 1'b0;
    seq[0] = 0;
    seq[1] = 0;
    bus.conv_done = 1'b0;
    bus.conv_data = '1;
    forever begin
      @(posedge clk);
      #2;
      bus.conv_done = 1'b0;
      bus.conv_data = '1;
      if (!reset_n) begin
        cd = 0;
        seq[0] = 0;
        seq[1] = 0;
      end else begin
        if (cd > 0) begin
          cd--;
          if (cd == 0) begin
            bus.conv_done = 1'b1;
            bus.conv_data = adc_val[pend_ch][seq[pend_ch] % 2];
            seq[pend_ch]++;
          end
        end
        if (bus.conv_start && !mute[bus.conv_ch]) begin
          cd = adc_lat;
          pend_ch = bus.conv_ch;
        end
      end
    end
  end

  // Reference model: a round is a list of pending conversions plus collected samples
  bit            m_live = 1'b0;
  bit            m_idle, m_busy, m_pub, m_pulse, m_rmode;
  int            m_age, en_age, m_cur;
  int            m_todo[$];
  logic [DW-1:0] s0[$], s1[$];
  logic          exp_start, exp_ch, exp_valid, exp_to, exp_ov;
  logic [DW-1:0] exp_p1, exp_p2;

  function automatic logic [DW-1:0] pub_val(input logic [DW-1:0] s[$]);
    if (s.size() >= 2) return DW'((int'(s[0]) + int'(s[1])) / 2);
    if (s.size() == 1) return s[0];
    return '0;
  endfunction

  task automatic launch();
    m_cur     = m_todo.pop_front();
    exp_ch    = m_cur[0];
    exp_start = 1'b1;
    m_pulse   = 1'b1;
  endtask

  always @(posedge clk) begin : model
    bit tick;
    m_live = 1'b1;
    if (!reset_n) begin
      m_idle = 1'b1; m_busy = 1'b0; m_pub = 1'b0; m_pulse = 1'b0; en_age = 0;
      exp_start = 1'b0; exp_ch = 1'b0; exp_valid = 1'b0;
      exp_p1 = '0; exp_p2 = '0; exp_to = 1'b0; exp_ov = 1'b0;
    end else if (!enable) begin
      m_idle = 1'b1; m_busy = 1'b0; m_pub = 1'b0; m_pulse = 1'b0; en_age = 0;
      exp_start = 1'b0; exp_valid = 1'b0;
    end else begin
      tick = (en_age % SAMPLE_DIV) == SAMPLE_DIV - 1;
      en_age++;
      exp_start = 1'b0;
      exp_valid = 1'b0;
      if (tick && (m_idle || m_busy)) exp_ov = 1'b1;
      if (m_idle) begin
        m_idle = 1'b0;
      end else if (!m_busy) begin
        if (tick) begin
          m_busy  = 1'b1;
          m_rmode = mode;
          m_todo.delete();
          s0.delete();
          s1.delete();
          for (int c = 0; c <= int'(mode); c++)
            for (int p = 0; p < NPASS; p++) m_todo.push_back(c);
          launch();
        end
      end else if (m_pub) begin
        m_pub  = 1'b0;
        m_busy = 1'b0;
      end else if (m_pulse) begin
        m_pulse = 1'b0;
        m_age   = 0;
      end else if (bus.conv_done) begin
        if (m_cur == 0) s0.push_back(bus.conv_data);
        else            s1.push_back(bus.conv_data);
        m_age = 0;
        if (m_todo.size() != 0) launch();
        else begin
          exp_valid = 1'b1;
          m_pub     = 1'b1;
          exp_p1    = pub_val(s0);
          if (m_rmode) exp_p2 = pub_val(s1);
        end
      end else if (m_age == TIMEOUT - 1) begin
        exp_to = 1'b1;
        m_busy = 1'b0;
      end else begin
        m_age++;
      end
    end
  end

  int n_start = 0;
  int n_valid = 0;

  initial begin
    forever begin
      @(negedge clk);
      if (m_live) begin
        chk("conv_start", 32'(bus.conv_start), 32'(exp_start));
        chk("sample_valid", 32'(sample_valid), 32'(exp_valid));
        chk("p1data", 32'(p1data), 32'(exp_p1));
        chk("p2data", 32'(p2data), 32'(exp_p2));
        chk("timeout_err", 32'(timeout_err), 32'(exp_to));
        chk("overrun", 32'(overrun), 32'(exp_ov));
        if (m_busy) chk("conv_ch", 32'(bus.conv_ch), 32'(exp_ch));
        if (bus.conv_start) n_start++;
        if (sample_valid) n_valid++;
      end
    end
  end

  task automatic set_vals(input logic [DW-1:0] a0, input logic [DW-1:0] a1,
                          input logic [DW-1:0] b0, input logic [DW-1:0] b1);
    adc_val[0][0] = a0; adc_val[0][1] = a1;
    adc_val[1][0] = b0; adc_val[1][1] = b1;
  endtask

  task automatic do_reset();
    reset_n = 1'b0;
    enable  = 1'b0;
    mute[0] = 1'b0;
    mute[1] = 1'b0;
    step(2);
    reset_n = 1'b1;
  endtask

  int v0, st0;

  initial begin
    reset_n = 1'b0;
    enable  = 1'b0;
    mode    = 1'b0;
    adc_lat = 3;
    mute[0] = 1'b0;
    mute[1] = 1'b0;
    set_vals('0, '0, '0, '0);
    step(3);
    reset_n = 1'b1;
    step(1);
    chk("rst p1data", 32'(p1data), 32'h0);
    chk("rst p2data", 32'(p2data), 32'h0);
    chk("rst valid", 32'(sample_valid), 32'h0);
    chk("rst conv_start", 32'(bus.conv_start), 32'h0);
    chk("rst timeout_err", 32'(timeout_err), 32'h0);
    chk("rst overrun", 32'(overrun), 32'h0);

`ifndef ADC_AVG_EN
    // 1: single mode, period 8, valid one cycle after done
    do_reset();
    set_vals(12'h3E8, 12'h3E8, 12'h000, 12'h000);
    mode = 1'b0; adc_lat = 3; enable = 1'b1;
    step(8);  chk("s1 start", 32'(bus.conv_start), 32'h1);
              chk("s1 ch", 32'(bus.conv_ch), 32'h0);
    step(4);  chk("s1 valid", 32'(sample_valid), 32'h1);
              chk("s1 p1", 32'(p1data), 32'h3E8);
              chk("s1 p2", 32'(p2data), 32'h000);
    step(4);  chk("s1 start2", 32'(bus.conv_start), 32'h1);
    step(4);  chk("s1 valid2", 32'(sample_valid), 32'h1);
    step(10);

    // 2: multi mode, ch0 then ch1, one publish
    do_reset();
    set_vals(12'h123, 12'h123, 12'hABC, 12'hABC);
    mode = 1'b1; adc_lat = 2; enable = 1'b1;
    step(8);  chk("s2 start ch0", 32'(bus.conv_ch), 32'h0);
    step(3);  chk("s2 start", 32'(bus.conv_start), 32'h1);
              chk("s2 start ch1", 32'(bus.conv_ch), 32'h1);
    step(3);  chk("s2 valid", 32'(sample_valid), 32'h1);
              chk("s2 p1", 32'(p1data), 32'h123);
              chk("s2 p2", 32'(p2data), 32'hABC);
    step(2);  chk("s2 overrun", 32'(overrun), 32'h0);
              chk("s2 next start", 32'(bus.conv_start), 32'h1);
    step(10);

    // 3: ch1 never answers -> timeout, round dropped, next round normal
    do_reset();
    set_vals(12'h055, 12'h055, 12'h0AA, 12'h0AA);
    mute[1] = 1'b1;
    mode = 1'b1; adc_lat = 3; enable = 1'b1;
    v0 = n_valid;
    step(28); chk("s3 to before", 32'(timeout_err), 32'h0);
    step(1);  chk("s3 to set", 32'(timeout_err), 32'h1);
              chk("s3 no valid", 32'(n_valid - v0), 32'h0);
              chk("s3 p1 held", 32'(p1data), 32'h000);
    mute[1] = 1'b0;
    step(3);  chk("s3 restart", 32'(bus.conv_start), 32'h1);
    step(8);  chk("s3 valid", 32'(sample_valid), 32'h1);
              chk("s3 p2", 32'(p2data), 32'h0AA);
    step(6);

    // 4: slow ADC -> overrun, rounds still publish
    do_reset();
    set_vals(12'h111, 12'h111, 12'h222, 12'h222);
    mode = 1'b1; adc_lat = 10; enable = 1'b1;
    step(15); chk("s4 ov before", 32'(overrun), 32'h0);
    step(1);  chk("s4 ov set", 32'(overrun), 32'h1);
    step(14); chk("s4 valid", 32'(sample_valid), 32'h1);
              chk("s4 p1", 32'(p1data), 32'h111);
              chk("s4 p2", 32'(p2data), 32'h222);
    step(24); chk("s4 valid2", 32'(sample_valid), 32'h1);
    step(4);

    // 5: enable dropped while waiting for ch1
    do_reset();
    set_vals(12'h321, 12'h321, 12'h654, 12'h654);
    mode = 1'b1; adc_lat = 3; enable = 1'b1;
    v0 = n_valid;
    step(13); chk("s5 ch1 wait", 32'(bus.conv_ch), 32'h1);
    enable = 1'b0;
    step(1);  chk("s5 no start", 32'(bus.conv_start), 32'h0);
    step(2);  enable = 1'b1;
    step(8);  chk("s5 restart", 32'(bus.conv_start), 32'h1);
              chk("s5 restart ch", 32'(bus.conv_ch), 32'h0);
              chk("s5 no valid", 32'(n_valid - v0), 32'h0);
    step(8);  chk("s5 valid", 32'(sample_valid), 32'h1);
              chk("s5 p1", 32'(p1data), 32'h321);
    step(4);
`else
    // 6: averaging, two passes per channel, DW+1-bit sum
    do_reset();
    set_vals(12'h100, 12'h103, 12'hFFF, 12'hFFD);
    mode = 1'b1; adc_lat = 1; enable = 1'b1;
    st0 = n_start;
    step(8);  chk("s6 start", 32'(bus.conv_start), 32'h1);
    step(8);  chk("s6 valid", 32'(sample_valid), 32'h1);
              chk("s6 p1", 32'(p1data), 32'h101);
              chk("s6 p2", 32'(p2data), 32'hFFE);
              chk("s6 starts", 32'(n_start - st0), 32'h4);
    do_reset();
    mode = 1'b0; adc_lat = 2; enable = 1'b1;
    step(30);
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
